regfile_2r1w_sb: RTL

- Parametrised general-purpose register file for the RISC-V core: two independent read ports, one write port, and an integrated busy-bit scoreboard.
- Replaces the single-port, write-priority register file. Decode reads both source operands every cycle and reserves the destination register.
- The writeback stage writes results and releases the reservation.

---
 rtl/regfile_2r1w_sb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_2r1w_sb.sv
// Two-read, one-write register file with a busy-bit scoreboard.
// Decode reserves destinations and writeback releases them; reads are registered.
module regfile_2r1w_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en_a,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  output logic            busy_a,
  input  logic            rd_en_b,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  output logic            busy_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [NREGS-1:0] busy_vec
);

  localparam logic [AW:0] NREGS_W = NREGS[AW:0];

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  rd_data_a_q, rd_data_a_d;
  logic [XLEN-1:0]  rd_data_b_q, rd_data_b_d;
  logic             busy_a_q, busy_a_d;
  logic             busy_b_q, busy_b_d;
  logic             wr_ok;
  logic             rsv_ok;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < NREGS_W;
  endfunction

  // Readable/writable storage: in range and not the hardwired zero register.
  function automatic logic is_real(input logic [AW-1:0] addr);
    return in_range(addr) && !(ZERO_REG && (addr == '0));
  endfunction

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    wr_ok  = wr_en && is_real(wr_addr);
    rsv_ok = rsv_en && is_real(rsv_addr);
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // A reservation by a younger instruction wins over a same-cycle release.
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    busy_a_d    = busy_a_q;
    if (rd_en_a) begin
      rd_data_a_d = '0;
      busy_a_d    = 1'b0;
      if (is_real(rd_addr_a)) begin
        busy_a_d = busy_d[rd_addr_a];
        if (BYPASS && wr_ok && (wr_addr == rd_addr_a)) begin
          rd_data_a_d = wr_data;
        end else begin
          rd_data_a_d = regs_q[rd_addr_a];
        end
      end
    end
  end

  always_comb begin
    rd_data_b_d = rd_data_b_q;
    busy_b_d    = busy_b_q;
    if (rd_en_b) begin
      rd_data_b_d = '0;
      busy_b_d    = 1'b0;
      if (is_real(rd_addr_b)) begin
        busy_b_d = busy_d[rd_addr_b];
        if (BYPASS && wr_ok && (wr_addr == rd_addr_b)) begin
          rd_data_b_d = wr_data;
        end else begin
          rd_data_b_d = regs_q[rd_addr_b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      busy_a_q    <= 1'b0;
      busy_b_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      busy_a_q    <= busy_a_d;
      busy_b_q    <= busy_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign busy_a    = busy_a_q;
  assign busy_b    = busy_b_q;
  assign busy_vec  = busy_q;

endmodule
